// File: rtl/reqrsp_share_arb.sv
// reqrsp_share_arb: round-robin share of one reqrsp master port among NrPorts requesters.
// Optional stall counter enabled by macro REQRSP_SHARE_ARB_STALL_CNT_EN.
package reqrsp_share_arb_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] data;
        logic [3:0]  strb;
    } q_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic        error;
    } p_chan_t;

    typedef struct packed {
        q_chan_t q;
        logic    q_valid;
        logic    p_ready;
    } req_t;

    typedef struct packed {
        p_chan_t p;
        logic    p_valid;
        logic    q_ready;
    } rsp_t;

endpackage

module reqrsp_share_arb #(
    parameter int unsigned NrPorts        = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         req_t          = reqrsp_share_arb_pkg::req_t,
    parameter type         rsp_t          = reqrsp_share_arb_pkg::rsp_t
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  req_t [NrPorts-1:0] slv_req_i,
    output rsp_t [NrPorts-1:0] slv_rsp_o,
    output req_t               mst_req_o,
    input  rsp_t               mst_rsp_i,
    output logic [31:0]        stall_cnt_o
);

    localparam int unsigned IdxW = (NrPorts > 1) ? $clog2(NrPorts) : 1;
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    if ($bits(req_t) != AddrWidth + DataWidth + DataWidth / 8 + 3) begin : g_bad_req
        $error("req_t does not match AddrWidth/DataWidth");
    end
    if ($bits(rsp_t) != DataWidth + 3) begin : g_bad_rsp
        $error("rsp_t does not match DataWidth");
    end

    logic [IdxW-1:0] r_rr;
    logic            r_lock;
    logic [IdxW-1:0] r_lock_idx;
    logic [IdxW-1:0] r_fifo [MaxOutstanding];
    logic [PtrW-1:0] r_wr;
    logic [PtrW-1:0] r_rd;
    logic [CntW-1:0] r_cnt;

    logic [IdxW-1:0] w_arb;
    logic [IdxW-1:0] w_win;
    logic [IdxW-1:0] w_head;
    logic            w_any;
    logic            w_full;
    logic            w_empty;
    logic            w_qv;
    logic            w_pready;
    logic            w_push;
    logic            w_pop;

    function automatic logic [PtrW-1:0] f_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full   = (r_cnt == CntW'(MaxOutstanding));
    assign w_empty  = (r_cnt == '0);
    assign w_head   = r_fifo[r_rd];
    assign w_win    = r_lock ? r_lock_idx : w_arb;
    assign w_qv     = w_any && !w_full && !rst_i;
    assign w_pready = slv_req_i[w_head].p_ready && !w_empty && !rst_i;
    assign w_push   = w_qv && mst_rsp_i.q_ready;
    assign w_pop    = w_pready && mst_rsp_i.p_valid;

    // Round-robin search: first valid port at or after the pointer.
    always_comb begin
        int p;
        p     = 0;
        w_any = 1'b0;
        w_arb = r_rr;
        for (int k = 0; k < int'(NrPorts); k++) begin
            p = int'(r_rr) + k;
            if (p >= int'(NrPorts)) p = p - int'(NrPorts);
            if (!w_any && slv_req_i[p].q_valid) begin
                w_any = 1'b1;
                w_arb = IdxW'(p);
            end
        end
    end

    // Route q from the winner and p back to the FIFO head.
    always_comb begin
        mst_req_o         = '0;
        mst_req_o.q       = slv_req_i[w_win].q;
        mst_req_o.q_valid = w_qv;
        mst_req_o.p_ready = w_pready;
        slv_rsp_o         = '0;
        for (int i = 0; i < int'(NrPorts); i++) begin
            slv_rsp_o[i].p = mst_rsp_i.p;
        end
        slv_rsp_o[w_win].q_ready  = mst_rsp_i.q_ready && !w_full && !rst_i;
        slv_rsp_o[w_head].p_valid = mst_rsp_i.p_valid && !w_empty && !rst_i;
    end

    // Arbitration pointer, grant lock and FIFO bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr       <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_push) begin
                r_lock <= 1'b0;
                r_rr   <= (w_win == IdxW'(NrPorts - 1)) ? '0 : w_win + 1'b1;
            end else if (w_qv) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_win;
            end
            if (w_push) r_wr <= f_inc(r_wr);
            if (w_pop) r_rd <= f_inc(r_rd);
            if (w_push && !w_pop) r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

    // Index storage needs no reset; occupancy is tracked by r_cnt.
    always_ff @(posedge clk_i) begin
        if (w_push) r_fifo[r_wr] <= w_win;
    end

`ifdef REQRSP_SHARE_ARB_STALL_CNT_EN
    logic [31:0] r_stall;

    // Saturating count of cycles with a pending request but no handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_stall <= '0;
        else if (w_any && !w_push && r_stall != '1) r_stall <= r_stall + 1'b1;
    end

    assign stall_cnt_o = r_stall;
`else
    assign stall_cnt_o = '0;
`endif

    for (genvar g = 0; g < NrPorts; g++) begin : g_chk
        a_q_stable : assert property (@(posedge clk_i) disable iff (rst_i)
            slv_req_i[g].q_valid && !slv_rsp_o[g].q_ready
            |=> slv_req_i[g].q_valid && $stable(slv_req_i[g].q));
    end

    a_p_empty : assert property (@(posedge clk_i) disable iff (rst_i)
        mst_rsp_i.p_valid |-> !w_empty);

endmodule
